imm_encoder: RTL
================

# imm_encoder

Packs an instruction type, register indices, funct3 and a 32-bit signed immediate into a 32-bit RV32I instruction word for the I-ALU, I-load, S-store and B-branch formats. It produces exactly the encodings the core's immediate extender expects to decode. The block sits in the program-load/test path, between the instruction generator and the instruction-memory writer. It is a two-stage valid/ready pipeline with full throughput, optional immediate range checking, and a count of emitted instructions.

## Interface
- No parameters.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input field set valid.
- in_ready  out  1  block can accept the input this cycle.
- in_type  in  2  format: 0=I-ALU (0010011), 1=I-load (0000011), 2=S (0100011), 3=B (1100011).
- in_rd, in_rs1, in_rs2  in  5 each  register indices; rd is ignored for S and B, rs2 is ignored for I.
- in_funct3  in  3  funct3 field.
- in_imm  in  32  signed immediate (byte offset for B).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts the word.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate was out of range (only with the range check compiled in).
- enc_count  out  16  number of output handshakes completed.

## Operation
- Stage 1 (S1) registers the input fields on an input handshake (in_valid && in_ready).
- Stage 2 (S2) encodes combinationally from S1 and registers out_instr and out_err.
- Encodings:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}. imm[0] is never encoded.
- Range rules:
  - I and S: imm[31:11] must be all equal, giving the range -2048..2047.
  - B: imm[31:12] must be all equal and imm[0]=0, giving the range -4096..4094, even values only.
- S2 loads from S1 when S1 is valid and either S2 is empty or out_ready=1.
- S1 loads on an input handshake.
- in_ready = !s1_valid || !s2_valid || out_ready. This path is combinational from out_ready; in_valid never combinationally drives any output.
- enc_count increments on each output handshake (out_valid && out_ready) and wraps from 0xFFFF to 0.
- Simultaneous input handshake and output handshake: both occur in the same cycle and the pipeline keeps one word per cycle.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, enc_count=0. in_ready=1 after reset.
- Latency: an input accepted at edge N gives out_valid=1 with the word after edge N+1.
- Throughput: 1 word per cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_instr and out_err hold stable.
  - With both stages full and out_ready=0, in_ready=0.
  - The pipeline holds at most 2 words.
- Reset mid-operation clears both valid flags asynchronously. In-flight words are dropped and enc_count returns to 0.
- out_instr changes only on an edge where S2 loads.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - An out-of-range immediate sets out_err=1 for that word.
  - out_instr is forced to 0x00000013 (NOP) for that word.
  - The word still completes the handshake and still counts in enc_count.
- IMM_RANGE_CHECK_EN undefined:
  - No check is performed; out_err is constant 0.
  - Immediates are silently truncated to their encodable bits; imm[0] is dropped for B.

## Test plan
- ADDI: type 0, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF -> out_instr=0xFFF10093, out_err=0, out_valid 2 cycles after accept.
- LW then SW back-to-back, out_ready=1:
  - LW: type 1, rd=3, rs1=0, funct3=2, imm=4 -> 0x00402183.
  - SW: type 2, rs2=5, rs1=2, funct3=2, imm=8 -> 0x00512423 on the next cycle.
  - enc_count=2 afterwards.
- BEQ: type 3, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3.
- ADDI with rd=1, rs1=2, imm=2048:
  - With IMM_RANGE_CHECK_EN: out_err=1, out_instr=0x00000013.
  - Without it: out_err=0, out_instr=0x80010093.
- Backpressure: hold out_ready=0 and offer 3 words -> 2 accepted, then in_ready=0 and out_instr stays stable. Release out_ready -> words emerge in order with no loss or duplication.
- Drive 65537 handshakes -> enc_count=1 (wrap). Assert rst_n low with 2 words in flight -> out_valid=0 and enc_count=0 immediately, no clock edge needed.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I I/S/B instruction packer: two-stage valid/ready pipeline with an output handshake counter.
// Define IMM_RANGE_CHECK_EN to flag out-of-range immediates (out_err=1, word replaced by NOP).
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned CNT_W = 16;

    localparam logic [6:0]      OPC_IALU   = 7'b0010011;
    localparam logic [6:0]      OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]      OPC_STORE  = 7'b0100011;
    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] NOP_WORD   = 32'h0000_0013;

    typedef enum logic [1:0] {
        FMT_IALU   = 2'd0,
        FMT_LOAD   = 2'd1,
        FMT_STORE  = 2'd2,
        FMT_BRANCH = 2'd3
    } fmt_t;

    typedef struct packed {
        fmt_t             fmt;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F3_W-1:0]  funct3;
        logic [XLEN-1:0]  imm;
    } fields_t;

    fields_t         s1_q;
    logic            s1_valid;
    logic            in_hs_c;
    logic            s2_load_c;
    logic            out_hs_c;
    logic [XLEN-1:0] enc_word_c;
    logic            enc_err_c;

    assign in_ready  = !s1_valid || !out_valid || out_ready;
    assign in_hs_c   = in_valid && in_ready;
    assign s2_load_c = s1_valid && (!out_valid || out_ready);
    assign out_hs_c  = out_valid && out_ready;

    // Field packing for the four supported formats.
    always_comb begin
        enc_word_c = '0;
        enc_err_c  = 1'b0;
        unique case (s1_q.fmt)
            FMT_IALU:  enc_word_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, OPC_IALU};
            FMT_LOAD:  enc_word_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, OPC_LOAD};
            FMT_STORE: enc_word_c = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                     s1_q.imm[4:0], OPC_STORE};
            default:   enc_word_c = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                                     s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], OPC_BRANCH};
        endcase
`ifdef IMM_RANGE_CHECK_EN
        // Upper bits must be a pure sign extension; branch offsets must also be even.
        if (s1_q.fmt == FMT_BRANCH) begin
            enc_err_c = !((&s1_q.imm[31:12]) || !(|s1_q.imm[31:12])) || s1_q.imm[0];
        end else begin
            enc_err_c = !((&s1_q.imm[31:11]) || !(|s1_q.imm[31:11]));
        end
        if (enc_err_c) begin
            enc_word_c = NOP_WORD;
        end
`endif
    end

`ifndef IMM_RANGE_CHECK_EN
    logic unused_imm_hi;
    assign unused_imm_hi = ^s1_q.imm[31:13];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_hs_c) begin
            s1_valid    <= 1'b1;
            s1_q.fmt    <= fmt_t'(in_type);
            s1_q.rd     <= in_rd;
            s1_q.rs1    <= in_rs1;
            s1_q.rs2    <= in_rs2;
            s1_q.funct3 <= in_funct3;
            s1_q.imm    <= in_imm;
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage holds its word until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_load_c) begin
            out_valid <= 1'b1;
            out_instr <= enc_word_c;
            out_err   <= enc_err_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (out_hs_c) begin
            enc_count <= enc_count + CNT_W'(1);
        end
    end

endmodule
